// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
//   Turns the two raw board push-buttons (left/right) into clean, debounced
//   levels for the ball movement stage. It also produces one-cycle press and
//   release strobes for the game-control logic.
//
//   Each channel passes through a two-flop synchronizer. It then goes through
//   a four-state debounce FSM. A new level is accepted only after the
//   synchronized input has held it for DEBOUNCE_CYCLES consecutive samples.
//   A raw edge held steady therefore appears on the stable level exactly
//   DEBOUNCE_CYCLES+2 clocks later.
//
// Parameters
//   DEBOUNCE_CYCLES : samples a new level must persist before commit (>= 2)
//   CNT_W           : per-channel counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports
//   clk          : system clock
//   rst          : synchronous, active-high reset
//   btn_raw[1:0] : asynchronous raw buttons, active-high, [1]=left [0]=right
//   btn[1:0]     : registered debounced (and optionally arbitrated) levels
//   btn_press    : one-cycle strobe on a channel's debounced 0->1 commit
//   btn_release  : one-cycle strobe on a channel's debounced 1->0 commit
//
// Configuration
//   BTN_LAST_WINS_EN : when defined, last-pressed-wins arbitration makes btn
//                      one-hot while both stable levels are high. When it is
//                      undefined, btn follows the stable levels directly.
// ----------------------------------------------------------------------------
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] btn_raw,
   output logic [1:0] btn,
   output logic [1:0] btn_press,
   output logic [1:0] btn_release
);

   localparam logic [1:0] STABLE_LO = 2'b00;
   localparam logic [1:0] WAIT_HI   = 2'b01;
   localparam logic [1:0] STABLE_HI = 2'b10;
   localparam logic [1:0] WAIT_LO   = 2'b11;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

   logic [1:0]            sync1_r;
   logic [1:0]            sync2_r;
   logic [1:0][1:0]       state_r;
   logic [1:0][1:0]       state_s;
   logic [1:0][CNT_W-1:0] cnt_r;
   logic [1:0][CNT_W-1:0] cnt_s;
   logic [1:0]            stable_s;
   logic [1:0]            press_s;
   logic [1:0]            release_s;
   logic [1:0]            btn_s;

   // Two-flop synchronizer on the asynchronous button inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 2'b00;
         sync2_r <= 2'b00;
      end else begin
         sync1_r <= btn_raw;
         sync2_r <= sync1_r;
      end
   end

   // Per-channel debounce FSM next-state, counter and commit strobes
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      stable_s  = 2'b00;
      press_s   = 2'b00;
      release_s = 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
         case (state_r[ch])
            STABLE_LO: begin
               if (sync2_r[ch]) begin
                  state_s[ch] = WAIT_HI;
                  cnt_s[ch]   = CNT_ONE;
               end else begin
                  state_s[ch] = STABLE_LO;
                  cnt_s[ch]   = CNT_ZERO;
               end
            end
            WAIT_HI: begin
               if (!sync2_r[ch]) begin
                  // bounce back: abandon the candidate without a strobe
                  state_s[ch] = STABLE_LO;
                  cnt_s[ch]   = CNT_ZERO;
               end else if (cnt_r[ch] == CNT_LAST) begin
                  state_s[ch] = STABLE_HI;
                  cnt_s[ch]   = CNT_ZERO;
                  press_s[ch] = 1'b1;
               end else begin
                  state_s[ch] = WAIT_HI;
                  cnt_s[ch]   = cnt_r[ch] + CNT_ONE;
               end
            end
            STABLE_HI: begin
               if (!sync2_r[ch]) begin
                  state_s[ch] = WAIT_LO;
                  cnt_s[ch]   = CNT_ONE;
               end else begin
                  state_s[ch] = STABLE_HI;
                  cnt_s[ch]   = CNT_ZERO;
               end
            end
            WAIT_LO: begin
               if (sync2_r[ch]) begin
                  state_s[ch] = STABLE_HI;
                  cnt_s[ch]   = CNT_ZERO;
               end else if (cnt_r[ch] == CNT_LAST) begin
                  state_s[ch]   = STABLE_LO;
                  cnt_s[ch]     = CNT_ZERO;
                  release_s[ch] = 1'b1;
               end else begin
                  state_s[ch] = WAIT_LO;
                  cnt_s[ch]   = cnt_r[ch] + CNT_ONE;
               end
            end
            default: begin
               state_s[ch] = STABLE_LO;
               cnt_s[ch]   = CNT_ZERO;
            end
         endcase
         // the accepted level stays high while a release is still being qualified
         stable_s[ch] = (state_s[ch] == STABLE_HI) || (state_s[ch] == WAIT_LO);
      end
   end

`ifdef BTN_LAST_WINS_EN
   logic [1:0] owner_r;
   logic [1:0] owner_s;

   // Owner follows the most recent press commit; a simultaneous double press clears it
   always_comb begin
      owner_s = owner_r;
      btn_s   = stable_s;
      if (press_s == 2'b11) begin
         owner_s = 2'b00;
      end else if (press_s[1]) begin
         owner_s = 2'b10;
      end else if (press_s[0]) begin
         owner_s = 2'b01;
      end else begin
         owner_s = owner_r;
      end
      if (stable_s == 2'b11) begin
         // owner cleared by a tie leaves both bits up, which means no motion
         if (owner_s == 2'b00) begin
            btn_s = 2'b11;
         end else begin
            btn_s = owner_s;
         end
      end else begin
         btn_s = stable_s;
      end
   end

   // Owner register
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_r <= 2'b00;
      end else begin
         owner_r <= owner_s;
      end
   end
`else
   // Without arbitration the output level is the stable level
   always_comb begin
      btn_s = stable_s;
   end
`endif

   // FSM state, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= {STABLE_LO, STABLE_LO};
         cnt_r       <= {CNT_ZERO, CNT_ZERO};
         btn         <= 2'b00;
         btn_press   <= 2'b00;
         btn_release <= 2'b00;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         btn         <= btn_s;
         btn_press   <= press_s;
         btn_release <= release_s;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
module tb_button_conditioner;

   localparam int D  = 16;
   localparam int CW = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] btn_raw;
   logic [1:0] btn;
   logic [1:0] btn_press;
   logic [1:0] btn_release;

   always #5 clk = ~clk;

   button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .btn         (btn),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int drive_cyc = 0;
   int press_cnt [2];
   int release_cnt [2];
   int last_press_cyc [2];
   int last_release_cyc [2];

   // expected {btn, btn_press, btn_release} after each clock edge
   logic [5:0] exp_q [$];

   // reference model: sampled-history view of the debouncer
   logic [1:0]   m_stable;
   logic [1:0]   m_owner;
   logic [D-1:0] m_win [2];
   int           m_filled [2];
   logic [1:0]   m_dly [$];

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
      end
   endtask

   // Predict the outputs produced by the next clock edge for the given inputs
   task automatic model_step(input logic r, input logic [1:0] raw);
      logic [1:0] s;
      logic [1:0] nxt;
      logic [1:0] pr;
      logic [1:0] rl;
      logic [1:0] b;
      if (r) begin
         m_stable = 2'b00;
         m_owner  = 2'b00;
         m_dly.delete();
         m_dly.push_back(2'b00);
         m_dly.push_back(2'b00);
         for (int c = 0; c < 2; c++) begin
            m_win[c]    = '0;
            m_filled[c] = 0;
         end
         exp_q.push_back(6'b000000);
      end else begin
         // value seen by the debouncer is the raw input two edges earlier
         s = m_dly.pop_front();
         m_dly.push_back(raw);
         nxt = m_stable;
         for (int c = 0; c < 2; c++) begin
            m_win[c] = {m_win[c][D-2:0], s[c]};
            if (m_filled[c] < D) m_filled[c]++;
            // accept a new level once the last D samples all disagree with the old one
            if (m_filled[c] == D && m_win[c] == (m_stable[c] ? {D{1'b0}} : {D{1'b1}}))
               nxt[c] = ~m_stable[c];
         end
         pr = nxt & ~m_stable;
         rl = ~nxt & m_stable;
`ifdef BTN_LAST_WINS_EN
         if (pr == 2'b11) m_owner = 2'b00;
         else if (pr[1])  m_owner = 2'b10;
         else if (pr[0])  m_owner = 2'b01;
         if (nxt == 2'b11) b = (m_owner == 2'b00) ? 2'b11 : m_owner;
         else b = nxt;
`else
         b = nxt;
`endif
         m_stable = nxt;
         exp_q.push_back({b, pr, rl});
      end
   endtask

   task automatic step(input logic r, input logic [1:0] raw);
      @(negedge clk);
      rst       = r;
      btn_raw   = raw;
      drive_cyc = cyc;
      model_step(r, raw);
   endtask

   task automatic hold(input logic [1:0] raw, input int n);
      repeat (n) step(1'b0, raw);
   endtask

   task automatic clear_stats();
      for (int c = 0; c < 2; c++) begin
         press_cnt[c]        = 0;
         release_cnt[c]      = 0;
         last_press_cyc[c]   = -1;
         last_release_cyc[c] = -1;
      end
   endtask

   // Monitor: pop one expectation per edge and compare, and log strobes
   initial begin
      logic [5:0] e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("outputs_cyc%0d", cyc), int'({btn, btn_press, btn_release}), int'(e));
         end
         for (int c = 0; c < 2; c++) begin
            if (btn_press[c] === 1'b1) begin
               press_cnt[c]++;
               last_press_cyc[c] = cyc;
            end
            if (btn_release[c] === 1'b1) begin
               release_cnt[c]++;
               last_release_cyc[c] = cyc;
            end
         end
      end
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      int rem [2];
      logic [1:0] rv;
      rst     = 1'b1;
      btn_raw = 2'b11;
      clear_stats();

      // 1: reset with both held, then both commit 18 edges after release of reset
      repeat (3) step(1'b1, 2'b11);
      clear_stats();
      step(1'b0, 2'b11);
      t0 = drive_cyc;
      hold(2'b11, 25);
      check("t1_lat_right", last_press_cyc[0] - t0, 18);
      check("t1_lat_left",  last_press_cyc[1] - t0, 18);
      check("t1_press_cnt", press_cnt[0] + press_cnt[1], 2);
      hold(2'b00, 25);

      // 2: single held edge on right
      clear_stats();
      step(1'b0, 2'b01);
      t0 = drive_cyc;
      hold(2'b01, 25);
      check("t2_lat", last_press_cyc[0] - t0, 18);
      check("t2_press_cnt", press_cnt[0], 1);
      hold(2'b00, 25);

      // 3: 15-cycle pulse rejected, 16-cycle pulse accepted
      clear_stats();
      hold(2'b10, 15);
      hold(2'b00, 25);
      check("t3_short_press", press_cnt[1], 0);
      check("t3_short_release", release_cnt[1], 0);
      clear_stats();
      hold(2'b10, 16);
      step(1'b0, 2'b00);
      t0 = drive_cyc;
      hold(2'b00, 25);
      check("t3_long_press", press_cnt[1], 1);
      check("t3_release_lat", last_release_cyc[1] - t0, 18);

      // 4: bounce train on right, then held high
      clear_stats();
      for (int k = 0; k < 8; k++) hold((k % 2 == 0) ? 2'b01 : 2'b00, 5);
      step(1'b0, 2'b01);
      t0 = drive_cyc;
      hold(2'b01, 25);
      check("t4_press_cnt", press_cnt[0], 1);
      check("t4_release_cnt", release_cnt[0], 0);
      check("t4_lat", last_press_cyc[0] - t0, 18);
      hold(2'b00, 25);

      // 5: right held, left pressed 20 cycles later
      hold(2'b01, 20);
      hold(2'b11, 30);
`ifdef BTN_LAST_WINS_EN
      check("t5_both_held", int'(btn), 2);
`else
      check("t5_both_held", int'(btn), 3);
`endif
      hold(2'b01, 25);
      check("t5_left_released", int'(btn), 1);
      hold(2'b00, 25);

      // 6: reset while counting (counter at 10 in WAIT_HI)
      clear_stats();
      step(1'b0, 2'b01);
      hold(2'b01, 11);
      step(1'b1, 2'b01);
      step(1'b0, 2'b01);
      t0 = drive_cyc;
      check("t6_after_rst", int'({btn, btn_press, btn_release}), 0);
      hold(2'b01, 25);
      check("t6_lat", last_press_cyc[0] - t0, 18);
      check("t6_press_cnt", press_cnt[0], 1);
      hold(2'b00, 25);

      // randomized hold lengths around the debounce window, rare resets
      rem[0] = 0;
      rem[1] = 0;
      rv     = 2'b00;
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < 2; c++) begin
            if (rem[c] == 0) begin
               rv[c]  = 1'($urandom_range(0, 1));
               rem[c] = int'($urandom_range(1, 40));
            end
            rem[c]--;
         end
         step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, rv);
      end

      hold(2'b00, 2);
      @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
